// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and word helpers for the block controller.
// Holds the IVs, the round-constant table and the small-sigma schedule functions.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int RND_W  = 7;

    typedef logic [WORD_W-1:0] word_t;

    // Working variables a..h; a sits in the MSBs so the layout matches the digest (H0 first).
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } work_t;

    typedef enum logic [1:0] {IDLE, ROUNDS, FINAL, DONE} state_t;

    localparam work_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam work_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t s_sigma_zero(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s_sigma_one(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        return {x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d,
                x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 round: purely combinational next {a..h} from current {a..h}, K and W.
// Latency: 0 cycles (registered by the caller).
// Backpressure: none; the controller decides when the result is captured.
module l_sigma_zero import sha256_pkg::*; (
    input  word_t x,
    output word_t y
);
    assign y = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
endmodule

module l_sigma_one import sha256_pkg::*; (
    input  word_t x,
    output word_t y
);
    assign y = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
endmodule

module choose import sha256_pkg::*; (
    input  word_t x,
    input  word_t y,
    input  word_t z,
    output word_t o
);
    assign o = (x & y) ^ (~x & z);
endmodule

module majority import sha256_pkg::*; (
    input  word_t x,
    input  word_t y,
    input  word_t z,
    output word_t o
);
    assign o = (x & y) ^ (x & z) ^ (y & z);
endmodule

module sha256_round import sha256_pkg::*; (
    input  work_t cur,
    input  word_t k,
    input  word_t w,
    output work_t nxt
);
    word_t big_s0, big_s1, ch, mj, t1, t2;

    l_sigma_zero u_s0  (.x(cur.a), .y(big_s0));
    l_sigma_one  u_s1  (.x(cur.e), .y(big_s1));
    choose       u_ch  (.x(cur.e), .y(cur.f), .z(cur.g), .o(ch));
    majority     u_maj (.x(cur.a), .y(cur.b), .z(cur.c), .o(mj));

    assign t1  = cur.h + big_s1 + ch + k + w;
    assign t2  = big_s0 + mj;
    assign nxt = {t1 + t2, cur.a, cur.b, cur.c, cur.d + t1, cur.e, cur.f, cur.g};
endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: accept a 512-bit block, run NUM_ROUNDS rounds, chain-add, present digest.
// Latency: out_valid rises 65 clocks after the accepting edge; in_ready only in IDLE.
// Backpressure: digest held in DONE until out_ready. Macro SHA256_SHA224_MODE_EN adds mode_224.
module sha256_block_ctrl #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORD_W-1:0]  blk,
    input  logic                  blk_first,
`ifdef SHA256_SHA224_MODE_EN
    input  logic                  mode_224,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*WORD_W-1:0]   digest,
    output logic                  busy
);
    import sha256_pkg::*;

    state_t             state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    word_t              w_q [16];
    word_t              w_d [16];
    work_t              work_q, work_d, h_q, h_d, digest_q, digest_d;
    work_t              round_nxt, init_val, iv_sel;
    logic               out_valid_q, out_valid_d;
    word_t              w_new;
`ifdef SHA256_SHA224_MODE_EN
    logic               mode_q, mode_d;
`endif

    sha256_round u_round (
        .cur (work_q),
        .k   (K[rnd_q[5:0]]),
        .w   (w_q[0]),
        .nxt (round_nxt)
    );

    // w_q[i] holds W[rnd+i]; the word entering slot 15 is W[rnd+16].
    assign w_new = s_sigma_one(w_q[14]) + w_q[9] + s_sigma_zero(w_q[1]) + w_q[0];

`ifdef SHA256_SHA224_MODE_EN
    assign iv_sel = mode_224 ? IV224 : IV256;
    assign digest = mode_q ? {digest_q[255:32], 32'h0} : digest_q;
`else
    assign iv_sel = IV256;
    assign digest = digest_q;
`endif

    assign init_val  = blk_first ? iv_sel : h_q;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        w_d         = w_q;
        work_d      = work_q;
        h_d         = h_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
`ifdef SHA256_SHA224_MODE_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    h_d    = init_val;
                    work_d = init_val;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk[16*WORD_W-1-WORD_W*i -: WORD_W];
                    end
                    rnd_d   = '0;
                    state_d = ROUNDS;
`ifdef SHA256_SHA224_MODE_EN
                    mode_d  = mode_224;
`endif
                end
            end
            ROUNDS: begin
                work_d = round_nxt;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_new;
                rnd_d   = rnd_q + RND_W'(1);
                if (rnd_q == RND_W'(NUM_ROUNDS - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                h_d         = add_work(h_q, work_q);
                digest_d    = add_work(h_q, work_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            work_q      <= '0;
            h_q         <= '0;
            digest_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef SHA256_SHA224_MODE_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            w_q         <= w_d;
            work_q      <= work_d;
            h_q         <= h_d;
            digest_q    <= digest_d;
            out_valid_q <= out_valid_d;
`ifdef SHA256_SHA224_MODE_EN
            mode_q      <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl: known digests, latency, backpressure, mid-block reset.
// Expected digests are queued on acceptance and compared at the output handshake.
module tb_sha256_block_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] blk = '0;
    logic         blk_first = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] digest;
    logic         busy;
`ifdef SHA256_SHA224_MODE_EN
    logic         mode_224 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_q [$];

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {448'h0, 64'h1c0};

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    sha256_block_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk       (blk),
        .blk_first (blk_first),
`ifdef SHA256_SHA224_MODE_EN
        .mode_224  (mode_224),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digest    (digest),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression used for the intermediate hash of the two-block message.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, bb, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] b, input logic first, input logic [255:0] exp);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", 256'(in_ready), 256'(1));
        blk       = b;
        blk_first = first;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        blk       = {16{$urandom}};
        exp_q.push_back(exp);
    endtask

    task automatic receive(input string tag, input int lat_exp, input int hold);
        int n = 0;
        logic [255:0] exp;
        logic [255:0] held;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (lat_exp >= 0) check({tag, "_latency"}, 256'(n), 256'(lat_exp));
        check({tag, "_out_valid"}, 256'(out_valid), 256'(1));
        exp  = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        held = digest;
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            blk_first = 1'b1;
            blk       = EMPTY_BLK;
            tick();
            check({tag, "_hold_digest"}, digest, held);
            check({tag, "_hold_in_ready"}, 256'(in_ready), 256'(0));
            check({tag, "_hold_out_valid"}, 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        check({tag, "_digest"}, digest, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 256'(out_valid), 256'(0));
        check({tag, "_digest_retained"}, digest, exp);
        check({tag, "_in_ready_after"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        repeat (3) tick();
        check("reset_in_ready", 256'(in_ready), 256'(1));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_digest", digest, 256'(0));
        rst_n = 1'b1;
        tick();

        send(ABC_BLK, 1'b1, ABC_DIG);
        check("busy_in_rounds", 256'(busy), 256'(1));
        check("in_ready_in_rounds", 256'(in_ready), 256'(0));
        receive("abc", 65, 0);

        send(EMPTY_BLK, 1'b1, EMPTY_DIG);
        receive("empty", 65, 0);

        send(TWO_B1, 1'b1, ref_compress(IV, TWO_B1));
        receive("two_blk1", 65, 0);
        send(TWO_B2, 1'b0, TWO_DIG);
        receive("two_blk2", 65, 0);

        send(ABC_BLK, 1'b1, ABC_DIG);
        receive("backpressure", 65, 20);
        repeat (3) tick();
        check("no_accept_during_hold", 256'(busy), 256'(0));

        send(EMPTY_BLK, 1'b1, EMPTY_DIG);
        repeat (31) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 256'(out_valid), 256'(0));
        check("midreset_digest", digest, 256'(0));
        check("midreset_busy", 256'(busy), 256'(0));
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(ABC_BLK, 1'b1, ABC_DIG);
        receive("abc_after_reset", 65, 0);

`ifdef SHA256_SHA224_MODE_EN
        mode_224 = 1'b1;
        send(ABC_BLK, 1'b1, {32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                             32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000});
        mode_224 = 1'b0;
        receive("sha224_abc", 65, 0);
        send(ABC_BLK, 1'b1, ABC_DIG);
        receive("abc_after_224", 65, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
